// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator and sample-scan scheduler.
// Maps 16-bit note commands ([15] on/off, [14:8] note, [7:0] velocity) onto
// VOICES slots. Each sample tick walks the slot table once and presents one
// voice per cycle to the generator bank.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a note-on that
// finds the table full overwrites the oldest slot. When it is undefined, that
// note-on is dropped and o_drop pulses.
module voice_allocator #(
    parameter int VOICES = 8,
    parameter int AGE_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_cmd_valid,
    input  logic [15:0]                i_cmd,
    output logic                       o_cmd_ready,
    input  logic                       i_sample_tick,
    output logic                       o_voice_valid,
    output logic [$clog2(VOICES)-1:0]  o_voice_idx,
    output logic [6:0]                 o_voice_note,
    output logic [7:0]                 o_voice_vel,
    output logic                       o_voice_active,
    output logic [VOICES-1:0]          o_active_mask,
    output logic                       o_drop,
    output logic                       o_overrun
);

    localparam int IDX_W = $clog2(VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [6:0]       NOTE_ALL = 7'h7F;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_SCAN   = 2'd3;

    // Command FSM and latched command.
    logic [1:0]        r_state;
    logic              r_cmd_on;
    logic              r_cmd_stop;
    logic [6:0]        r_cmd_note;
    logic [7:0]        r_cmd_vel;
    logic              r_tick_pend;

    // Search bookkeeping.
    logic [IDX_W-1:0]  r_srch_idx;
    logic              r_match_found;
    logic [IDX_W-1:0]  r_match_idx;
    logic              r_free_found;
    logic [IDX_W-1:0]  r_free_idx;
`ifdef VOICE_STEAL_EN
    logic              r_old_found;
    logic [IDX_W-1:0]  r_old_idx;
    logic [AGE_W-1:0]  r_old_age;
`endif

    // Slot table.
    logic [VOICES-1:0] r_active;
    logic [6:0]        r_note [VOICES];
    logic [7:0]        r_vel  [VOICES];
    logic [AGE_W-1:0]  r_age  [VOICES];

    // Next-state slot table (differs from the current one only in COMMIT).
    logic [VOICES-1:0] w_active;
    logic [6:0]        w_note [VOICES];
    logic [7:0]        w_vel  [VOICES];
    logic [AGE_W-1:0]  w_age  [VOICES];
    logic              w_drop;
    logic              w_tgt_vld;
    logic [IDX_W-1:0]  w_tgt;

    // Scan output registers.
    logic              r_voice_valid;
    logic [IDX_W-1:0]  r_voice_idx;
    logic [6:0]        r_voice_note;
    logic [7:0]        r_voice_vel;
    logic              r_voice_active;
    logic              r_drop;
    logic              r_overrun;
    logic              w_scan_load;
    logic [IDX_W-1:0]  w_scan_idx;

    // Saturating age increment.
    function automatic logic [AGE_W-1:0] f_age_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + AGE_W'(1);
    endfunction

    assign o_cmd_ready    = (r_state == S_IDLE) && !i_sample_tick;
    assign o_active_mask  = r_active;
    assign o_voice_valid  = r_voice_valid;
    assign o_voice_idx    = r_voice_idx;
    assign o_voice_note   = r_voice_note;
    assign o_voice_vel    = r_voice_vel;
    assign o_voice_active = r_voice_active;
    assign o_drop         = r_drop;
    assign o_overrun      = r_overrun;

    // Compute the table update applied at the end of the COMMIT cycle.
    always_comb begin
        w_active  = r_active;
        w_note    = r_note;
        w_vel     = r_vel;
        w_age     = r_age;
        w_drop    = 1'b0;
        w_tgt_vld = 1'b0;
        w_tgt     = '0;
        if (r_state == S_COMMIT) begin
            if (r_cmd_stop) begin
                w_active = '0;
            end else if (!r_cmd_on) begin
                if (r_match_found) w_active[r_match_idx] = 1'b0;
            end else begin
                if (r_match_found) begin
                    w_tgt_vld = 1'b1;
                    w_tgt     = r_match_idx;
                end else if (r_free_found) begin
                    w_tgt_vld = 1'b1;
                    w_tgt     = r_free_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    w_tgt_vld = 1'b1;
                    w_tgt     = r_old_idx;
`else
                    w_drop    = 1'b1;
`endif
                end
                if (w_tgt_vld) begin
                    // Every other sounding slot gets one step older.
                    for (int i = 0; i < VOICES; i++) begin
                        if (r_active[i] && (IDX_W'(i) != w_tgt))
                            w_age[i] = f_age_inc(r_age[i]);
                    end
                    w_active[w_tgt] = 1'b1;
                    w_note[w_tgt]   = r_cmd_note;
                    w_vel[w_tgt]    = r_cmd_vel;
                    w_age[w_tgt]    = '0;
                end
            end
        end
    end

    // Decide whether a scan output is loaded this cycle and which slot.
    always_comb begin
        w_scan_load = 1'b0;
        w_scan_idx  = '0;
        case (r_state)
            S_IDLE:   w_scan_load = i_sample_tick;
            S_COMMIT: w_scan_load = r_tick_pend || i_sample_tick;
            S_SCAN: begin
                w_scan_load = (r_voice_idx != LAST_IDX);
                w_scan_idx  = r_voice_idx + IDX_W'(1);
            end
            default:  w_scan_load = 1'b0;
        endcase
    end

    // Slot table storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_active <= w_active;
            r_note   <= w_note;
            r_vel    <= w_vel;
            r_age    <= w_age;
        end
    end

    // Command FSM: accept, search the table, commit, hand off to the scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cmd_on      <= 1'b0;
            r_cmd_stop    <= 1'b0;
            r_cmd_note    <= '0;
            r_cmd_vel     <= '0;
            r_tick_pend   <= 1'b0;
            r_srch_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
`ifdef VOICE_STEAL_EN
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_sample_tick) begin
                        r_state <= S_SCAN;
                    end else if (i_cmd_valid) begin
                        r_cmd_on      <= i_cmd[15];
                        r_cmd_note    <= i_cmd[14:8];
                        r_cmd_vel     <= i_cmd[7:0];
                        r_cmd_stop    <= !i_cmd[15] && (i_cmd[14:8] == NOTE_ALL);
                        r_srch_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
`ifdef VOICE_STEAL_EN
                        r_old_found   <= 1'b0;
`endif
                        r_state <= (!i_cmd[15] && (i_cmd[14:8] == NOTE_ALL)) ? S_COMMIT : S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (i_sample_tick) r_tick_pend <= 1'b1;
                    if (!r_match_found && r_active[r_srch_idx] && (r_note[r_srch_idx] == r_cmd_note)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_srch_idx;
                    end
                    if (!r_free_found && !r_active[r_srch_idx]) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_srch_idx;
                    end
`ifdef VOICE_STEAL_EN
                    // Strict compare keeps the lowest index on equal ages.
                    if (r_active[r_srch_idx] && (!r_old_found || (r_age[r_srch_idx] > r_old_age))) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_srch_idx;
                        r_old_age   <= r_age[r_srch_idx];
                    end
`endif
                    if (r_srch_idx == LAST_IDX) r_state <= S_COMMIT;
                    else                        r_srch_idx <= r_srch_idx + IDX_W'(1);
                end
                S_COMMIT: begin
                    r_tick_pend <= 1'b0;
                    r_state     <= (r_tick_pend || i_sample_tick) ? S_SCAN : S_IDLE;
                end
                S_SCAN: begin
                    if (r_voice_idx == LAST_IDX) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered scan outputs and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_voice_valid  <= 1'b0;
            r_voice_idx    <= '0;
            r_voice_note   <= '0;
            r_voice_vel    <= '0;
            r_voice_active <= 1'b0;
            r_drop         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_voice_valid <= w_scan_load;
            if (w_scan_load) begin
                r_voice_idx    <= w_scan_idx;
                r_voice_note   <= w_note[w_scan_idx];
                r_voice_vel    <= w_vel[w_scan_idx];
                r_voice_active <= w_active[w_scan_idx];
            end else begin
                r_voice_idx    <= '0;
                r_voice_note   <= '0;
                r_voice_vel    <= '0;
                r_voice_active <= 1'b0;
            end
            r_drop    <= w_drop;
            r_overrun <= (r_state == S_SCAN) && i_sample_tick;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed steps plus randomized commands,
// checked against a slot-table reference model.
module tb_voice_allocator;

    localparam int V    = 8;
    localparam int AW   = 4;
    localparam int AMAX = (1 << AW) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_cmd_valid = 1'b0;
    logic [15:0]  i_cmd = '0;
    logic         i_sample_tick = 1'b0;
    logic         o_cmd_ready;
    logic         o_voice_valid;
    logic [2:0]   o_voice_idx;
    logic [6:0]   o_voice_note;
    logic [7:0]   o_voice_vel;
    logic         o_voice_active;
    logic [V-1:0] o_active_mask;
    logic         o_drop;
    logic         o_overrun;

    int checks = 0;
    int errors = 0;

    // Reference slot table.
    bit m_act  [V];
    int m_note [V];
    int m_vel  [V];
    int m_age  [V];

    voice_allocator #(.VOICES(V), .AGE_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .o_cmd_ready    (o_cmd_ready),
        .i_sample_tick  (i_sample_tick),
        .o_voice_valid  (o_voice_valid),
        .o_voice_idx    (o_voice_idx),
        .o_voice_note   (o_voice_note),
        .o_voice_vel    (o_voice_vel),
        .o_voice_active (o_voice_active),
        .o_active_mask  (o_active_mask),
        .o_drop         (o_drop),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < V; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < V; i++) m[i] = m_act[i];
        return m;
    endfunction

    // Apply one command to the model; returns 1 when the note-on is dropped.
    function automatic bit m_apply(input logic [15:0] c);
        int note = int'(c[14:8]);
        int tgt = -1;
        int oldest = -1;
        if (!c[15] && note == 127) begin
            for (int i = 0; i < V; i++) m_act[i] = 0;
            return 0;
        end
        for (int i = 0; i < V; i++)
            if (tgt < 0 && m_act[i] && m_note[i] == note) tgt = i;
        if (!c[15]) begin
            if (tgt >= 0) m_act[tgt] = 0;
            return 0;
        end
        for (int i = 0; i < V; i++)
            if (tgt < 0 && !m_act[i]) tgt = i;
        for (int i = 0; i < V; i++)
            if (m_act[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
        if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
            tgt = oldest;
`else
            return 1;
`endif
        end
        for (int i = 0; i < V; i++)
            if (i != tgt && m_act[i] && m_age[i] < AMAX) m_age[i]++;
        m_act[tgt] = 1; m_note[tgt] = note; m_vel[tgt] = int'(c[7:0]); m_age[tgt] = 0;
        return 0;
    endfunction

    // Send one command from IDLE and check the mask/drop at the commit latency.
    task automatic send_cmd(input logic [15:0] c, input string tag);
        int lat;
        int guard = 0;
        bit exp_drop;
        @(negedge clk);
        while (!o_cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(o_cmd_ready), 1);
        i_cmd_valid = 1'b1;
        i_cmd = c;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        lat = (!c[15] && c[14:8] == 7'h7F) ? 2 : V + 2;
        exp_drop = m_apply(c);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        check({tag, "_mask"}, 32'(o_active_mask), m_mask());
        check({tag, "_drop"}, 32'(o_drop), 32'(exp_drop));
    endtask

    // Pulse a tick in IDLE (optionally with a competing command) and check the scan.
    task automatic do_scan(input bit with_cmd, input string tag);
        logic [31:0] mask_before;
        @(negedge clk);
        mask_before = 32'(o_active_mask);
        i_sample_tick = 1'b1;
        if (with_cmd) begin
            i_cmd_valid = 1'b1;
            i_cmd = 16'hB455;
            #1 check({tag, "_ready_low"}, 32'(o_cmd_ready), 0);
        end
        @(posedge clk);
        #1 i_sample_tick = 1'b0;
        i_cmd_valid = 1'b0;
        for (int k = 0; k < V; k++) begin
            @(negedge clk);
            check($sformatf("%s_valid%0d", tag, k), 32'(o_voice_valid), 1);
            check($sformatf("%s_idx%0d", tag, k), 32'(o_voice_idx), k);
            check($sformatf("%s_note%0d", tag, k), 32'(o_voice_note), m_note[k]);
            check($sformatf("%s_vel%0d", tag, k), 32'(o_voice_vel), m_vel[k]);
            check($sformatf("%s_act%0d", tag, k), 32'(o_voice_active), 32'(m_act[k]));
        end
        @(negedge clk);
        check({tag, "_valid_end"}, 32'(o_voice_valid), 0);
        check({tag, "_ready_end"}, 32'(o_cmd_ready), 1);
        check({tag, "_mask_kept"}, 32'(o_active_mask), mask_before);
    endtask

    // Tick during SEARCH is deferred to after COMMIT; a tick during SCAN overruns.
    task automatic overrun_test();
        int nvalid = 0;
        int nover = 0;
        bit exp_drop;
        bit ev;
        logic [15:0] c = 16'hC621;
        @(negedge clk);
        check("ovr_ready", 32'(o_cmd_ready), 1);
        i_cmd_valid = 1'b1;
        i_cmd = c;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        exp_drop = m_apply(c);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            ev = (cyc >= 10 && cyc <= 17);
            check($sformatf("ovr_valid_c%0d", cyc), 32'(o_voice_valid), 32'(ev));
            if (ev) begin
                check($sformatf("ovr_idx_c%0d", cyc), 32'(o_voice_idx), cyc - 10);
                check($sformatf("ovr_note_c%0d", cyc), 32'(o_voice_note), m_note[cyc - 10]);
            end
            check($sformatf("ovr_overrun_c%0d", cyc), 32'(o_overrun), 32'(cyc == 13));
            if (cyc <= 17) check($sformatf("ovr_busy_c%0d", cyc), 32'(o_cmd_ready), 0);
            if (cyc == 10) begin
                check("ovr_mask", 32'(o_active_mask), m_mask());
                check("ovr_drop", 32'(o_drop), 32'(exp_drop));
            end
            if (o_voice_valid) nvalid++;
            if (o_overrun) nover++;
            if (cyc == 2 || cyc == 12) i_sample_tick = 1'b1;
            if (cyc == 3 || cyc == 13) i_sample_tick = 1'b0;
        end
        check("ovr_nvalid", 32'(nvalid), V);
        check("ovr_npulse", 32'(nover), 1);
    endtask

    initial begin
        logic [15:0] c;
        logic [6:0]  n;
        int r;

        // Reset state.
        m_clear();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_cmd_ready), 1);
        check("rst_valid", 32'(o_voice_valid), 0);
        check("rst_idx", 32'(o_voice_idx), 0);
        check("rst_note", 32'(o_voice_note), 0);
        check("rst_vel", 32'(o_voice_vel), 0);
        check("rst_act", 32'(o_voice_active), 0);
        check("rst_mask", 32'(o_active_mask), 0);
        check("rst_drop", 32'(o_drop), 0);
        check("rst_overrun", 32'(o_overrun), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single note on, scan, off, off of a silent note.
        send_cmd(16'hB200, "on50");
        check("on50_mask_const", 32'(o_active_mask), 32'h01);
        do_scan(0, "scan_on50");
        send_cmd(16'h3200, "off50");
        send_cmd(16'h4900, "off73");
        check("off73_mask_const", 32'(o_active_mask), 32'h00);

        // Fill the table, then one more note-on.
        send_cmd(16'h7F00, "stop_a");
        for (int k = 20; k <= 27; k++) begin
            c = {1'b1, 7'(k), 8'($urandom_range(0, 255))};
            send_cmd(c, $sformatf("fill%0d", k));
        end
        send_cmd({1'b1, 7'd28, 8'h44}, "on28_full");
        check("full_mask_const", 32'(o_active_mask), 32'hFF);
        do_scan(0, "scan_full");

        // Retrigger of the same note.
        send_cmd(16'h7F00, "stop_b");
        send_cmd(16'hBC10, "on60a");
        send_cmd(16'hBC7F, "on60b");
        check("retrig_mask_const", 32'(o_active_mask), 32'h01);
        do_scan(0, "scan_retrig");

        // Five notes, then stop-all.
        send_cmd(16'h7F00, "stop_c");
        for (int k = 0; k < 5; k++)
            send_cmd({1'b1, 7'(30 + k), 8'(k * 17)}, $sformatf("five%0d", k));
        send_cmd(16'h7F00, "stop_five");
        check("stop_mask_const", 32'(o_active_mask), 32'h00);

        // Tick deferral and overrun.
        overrun_test();

        // Tick and command in the same IDLE cycle.
        do_scan(1, "scan_tickwins");

        // Randomized commands.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            n = 7'($urandom_range(40, 51));
            if (r == 0)      c = 16'h7F00;
            else if (r < 4)  c = {1'b0, n, 8'($urandom_range(0, 255))};
            else             c = {1'b1, n, 8'($urandom_range(0, 255))};
            send_cmd(c, $sformatf("rnd%0d", it));
            if (it % 8 == 7) do_scan(0, $sformatf("rscan%0d", it));
        end

        // Reset during SEARCH loses the in-flight command.
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd = 16'hA155;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_mask", 32'(o_active_mask), 0);
        check("midrst_ready", 32'(o_cmd_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        m_clear();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("midrst_hold_mask%0d", k), 32'(o_active_mask), 0);
            check($sformatf("midrst_hold_drop%0d", k), 32'(o_drop), 0);
        end
        do_scan(0, "scan_after_rst");
        send_cmd(16'hA155, "after_rst_on");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
